// File: rtl/l2_snoop_responder.sv
// Purpose : L2-side snoop responder; serves L1 miss reads from a local line store and absorbs evictions.
// Latency : response valid LATENCY cycles after read acceptance; held while hotlink_interrupt is high.
// Backpr. : no stall path; evictions always accepted, reads outside IDLE dropped and flagged sticky.
//
// Ports:
//   clk, reset              - single clock, asynchronous active-high reset
//   snooper_addr            - line address from the L1 (bits [3:0] ignored)
//   snooper_read_valid      - one-cycle miss read request
//   eviction_wren           - write evictable_cacheline into the store at snooper_addr
//   evictable_cacheline     - eviction write data
//   hotlink_interrupt       - L1 cannot take updates this cycle; response is held
//   updated_cacheline       - response line data (zero outside RESP)
//   cacheline_update_valid  - response valid
//   busy                    - registered "state is not IDLE"
//   protocol_error          - sticky: a read arrived while not IDLE
//   read_count, write_count - wrapping counts of accepted reads / eviction cycles
module l2_snoop_responder #(
    parameter int LATENCY        = 4,
    parameter int MEM_LINES_LOG2 = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  snooper_addr,
    input  logic         snooper_read_valid,
    input  logic         eviction_wren,
    input  logic [127:0] evictable_cacheline,
    input  logic         hotlink_interrupt,
    output logic [127:0] updated_cacheline,
    output logic         cacheline_update_valid,
    output logic         busy,
    output logic         protocol_error,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count
);

    localparam int       DEPTH   = 1 << MEM_LINES_LOG2;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                    state;
    logic [7:0]                lat_cnt;
    logic [MEM_LINES_LOG2-1:0] rd_idx;
    logic [MEM_LINES_LOG2-1:0] addr_idx;
    logic [127:0]              mem [DEPTH];

    // Upper address bits alias onto the same lines; low nibble is the byte offset.
    assign addr_idx = snooper_addr[4 +: MEM_LINES_LOG2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{snooper_addr[31:4+MEM_LINES_LOG2], snooper_addr[3:0]};

    // Store is deliberately outside the reset domain so evicted lines survive a reset.
    always_ff @(posedge clk) begin
        if (eviction_wren) begin
            mem[addr_idx] <= evictable_cacheline;
        end
    end

    // The store is read at response time, not at acceptance, so any write landing
    // during WAIT (or in the acceptance cycle itself) is forwarded naturally, while a
    // write during RESP only becomes visible after its edge.
    assign cacheline_update_valid = (state == RESP);
    assign updated_cacheline      = (state == RESP) ? mem[rd_idx] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            rd_idx         <= '0;
            busy           <= 1'b0;
            protocol_error <= 1'b0;
            read_count     <= '0;
            write_count    <= '0;
        end else begin
            if (eviction_wren) begin
                write_count <= write_count + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (snooper_read_valid) begin
                        rd_idx     <= addr_idx;
                        read_count <= read_count + 16'd1;
                        busy       <= 1'b1;
                        if (LATENCY == 1) begin
                            state   <= RESP;
                            lat_cnt <= '0;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    if (snooper_read_valid) begin
                        protocol_error <= 1'b1;
                    end
                    // Leaving at count 1 puts the first RESP cycle LATENCY edges after acceptance.
                    lat_cnt <= lat_cnt - 8'd1;
                    if (lat_cnt == 8'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (snooper_read_valid) begin
                        protocol_error <= 1'b1;
                    end
                    if (!hotlink_interrupt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Purpose : directed-vector bench for l2_snoop_responder (LATENCY=4 and LATENCY=1 instances).
// Latency : inputs driven 1ns after each rising edge, outputs sampled 2ns later.
// Backpr. : none; both instances share one stimulus stream, each checked only in its own phases.
module tb_l2_snoop_responder;

    logic         clk;
    logic         reset;
    logic [31:0]  snooper_addr;
    logic         snooper_read_valid;
    logic         eviction_wren;
    logic [127:0] evictable_cacheline;
    logic         hotlink_interrupt;

    logic [127:0] d4_line, d1_line;
    logic         d4_vld, d1_vld;
    logic         d4_busy, d1_busy;
    logic         d4_perr, d1_perr;
    logic [15:0]  d4_rc, d1_rc, d4_wc, d1_wc;

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [127:0] D1 = 128'hDEAD0000_00000000_00000000_00000001;
    localparam logic [127:0] D2 = 128'h22222222_33333333_44444444_55555555;
    localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] D4 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] D5 = 128'h5;

    l2_snoop_responder #(.LATENCY(4), .MEM_LINES_LOG2(10)) dut4 (
        .clk                    (clk),
        .reset                  (reset),
        .snooper_addr           (snooper_addr),
        .snooper_read_valid     (snooper_read_valid),
        .eviction_wren          (eviction_wren),
        .evictable_cacheline    (evictable_cacheline),
        .hotlink_interrupt      (hotlink_interrupt),
        .updated_cacheline      (d4_line),
        .cacheline_update_valid (d4_vld),
        .busy                   (d4_busy),
        .protocol_error         (d4_perr),
        .read_count             (d4_rc),
        .write_count            (d4_wc)
    );

    l2_snoop_responder #(.LATENCY(1), .MEM_LINES_LOG2(10)) dut1 (
        .clk                    (clk),
        .reset                  (reset),
        .snooper_addr           (snooper_addr),
        .snooper_read_valid     (snooper_read_valid),
        .eviction_wren          (eviction_wren),
        .evictable_cacheline    (evictable_cacheline),
        .hotlink_interrupt      (hotlink_interrupt),
        .updated_cacheline      (d1_line),
        .cacheline_update_valid (d1_vld),
        .busy                   (d1_busy),
        .protocol_error         (d1_perr),
        .read_count             (d1_rc),
        .write_count            (d1_wc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic rv, input logic [31:0] a, input logic wr,
                          input logic [127:0] d, input logic hi);
        snooper_read_valid  = rv;
        snooper_addr        = a;
        eviction_wren       = wr;
        evictable_cacheline = d;
        hotlink_interrupt   = hi;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: the next edge is the first after reset release.
    task automatic do_reset();
        set_in(1'b0, 32'h0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // LATENCY=4 read issued in cycle 0: valid only in cycle 4 carrying exp.
    task automatic read_expect(input string tag, input logic [31:0] a, input logic [127:0] exp);
        for (int c = 0; c < 7; c++) begin
            set_in(c == 0, a, 1'b0, '0, 1'b0);
            #2;
            chk({tag, "_vld"}, 128'(d4_vld), 128'(c == 4));
            if (c == 4) chk({tag, "_dat"}, d4_line, exp);
            next_cycle();
        end
    endtask

    initial begin
        set_in(1'b0, 32'h0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        next_cycle();
        chk("rst_vld",  128'(d4_vld),  128'(0));
        chk("rst_dat",  d4_line,       '0);
        chk("rst_busy", 128'(d4_busy), 128'(0));
        chk("rst_perr", 128'(d4_perr), 128'(0));
        chk("rst_rc",   128'(d4_rc),   128'(0));
        chk("rst_wc",   128'(d4_wc),   128'(0));

        // Write then read the same line; first edge after release accepts the write.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c == 0)      set_in(1'b0, 32'h0000_1230, 1'b1, D1, 1'b0);
            else if (c == 2) set_in(1'b1, 32'h0000_1230, 1'b0, '0, 1'b0);
            else             set_in(1'b0, 32'h0, 1'b0, '0, 1'b0);
            #2;
            chk("wr_rd_vld",  128'(d4_vld),  128'(c == 6));
            chk("wr_rd_busy", 128'(d4_busy), 128'(c >= 3 && c <= 6));
            if (c == 6) chk("wr_rd_dat", d4_line, D1);
            next_cycle();
        end
        chk("wr_rd_rc", 128'(d4_rc), 128'(1));
        chk("wr_rd_wc", 128'(d4_wc), 128'(1));

        // Eviction during WAIT to the pending line is forwarded into the response.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c == 0)      set_in(1'b1, 32'h0000_0040, 1'b0, '0, 1'b0);
            else if (c == 1) set_in(1'b0, 32'h0000_0040, 1'b1, D5, 1'b0);
            else             set_in(1'b0, 32'h0, 1'b0, '0, 1'b0);
            #2;
            chk("fwd_vld", 128'(d4_vld), 128'(c == 4));
            if (c == 4) chk("fwd_dat", d4_line, D5);
            next_cycle();
        end

        // hotlink_interrupt holds the response for two extra cycles.
        for (int c = 0; c < 9; c++) begin
            set_in(c == 0, 32'h0000_1230, 1'b0, '0, (c == 4 || c == 5));
            #2;
            chk("hold_vld", 128'(d4_vld), 128'(c >= 4 && c <= 6));
            if (c == 5) chk("hold_dat", d4_line, D1);
            if (c == 7) chk("hold_busy", 128'(d4_busy), 128'(0));
            next_cycle();
        end

        // Second read while WAIT is ignored and flagged.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c == 0)      set_in(1'b1, 32'h0000_0040, 1'b0, '0, 1'b0);
            else if (c == 2) set_in(1'b1, 32'h0000_1230, 1'b0, '0, 1'b0);
            else             set_in(1'b0, 32'h0, 1'b0, '0, 1'b0);
            #2;
            chk("perr_vld", 128'(d4_vld), 128'(c == 4));
            if (c == 4) chk("perr_dat", d4_line, D5);
            if (c == 1) chk("perr_pre", 128'(d4_perr), 128'(0));
            if (c == 3) chk("perr_set", 128'(d4_perr), 128'(1));
            next_cycle();
        end
        chk("perr_rc", 128'(d4_rc), 128'(1));

        // Asynchronous reset in the middle of a pending read; a committed write survives.
        for (int c = 0; c < 11; c++) begin
            if (c == 0)      set_in(1'b1, 32'h0000_1230, 1'b0, '0, 1'b0);
            else if (c == 1) set_in(1'b0, 32'h0000_2000, 1'b1, D2, 1'b0);
            else             set_in(1'b0, 32'h0, 1'b0, '0, 1'b0);
            if (c == 4) reset = 1'b0;
            #2;
            if (c == 2) begin
                chk("arst_pre_busy", 128'(d4_busy), 128'(1));
                chk("arst_pre_perr", 128'(d4_perr), 128'(1));
                reset = 1'b1;
                #1;
                chk("arst_busy", 128'(d4_busy), 128'(0));
                chk("arst_perr", 128'(d4_perr), 128'(0));
                chk("arst_rc",   128'(d4_rc),   128'(0));
                chk("arst_wc",   128'(d4_wc),   128'(0));
            end
            chk("arst_vld", 128'(d4_vld), 128'(0));
            next_cycle();
        end
        read_expect("arst_reread_new", 32'h0000_2000, D2);
        read_expect("arst_reread_old", 32'h0000_1230, D1);

        // LATENCY=1 instance: aliasing reads and same-cycle read+write in IDLE.
        for (int c = 0; c < 10; c++) begin
            if (c == 0)      set_in(1'b0, 32'h0000_0000, 1'b1, D3, 1'b0);
            else if (c == 1) set_in(1'b1, 32'h0000_0000, 1'b0, '0, 1'b0);
            else if (c == 4) set_in(1'b1, 32'h0000_4000, 1'b0, '0, 1'b0);
            else if (c == 7) set_in(1'b1, 32'h0000_0100, 1'b1, D4, 1'b0);
            else             set_in(1'b0, 32'h0, 1'b0, '0, 1'b0);
            #2;
            chk("l1_vld", 128'(d1_vld), 128'(c == 2 || c == 5 || c == 8));
            if (c == 2) chk("l1_dat_a", d1_line, D3);
            if (c == 5) chk("l1_dat_alias", d1_line, D3);
            if (c == 8) chk("l1_dat_rw", d1_line, D4);
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_snoop_responder.md
L2_SNOOP_RESPONDER -- requirements
Module: l2_snoop_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from read acceptance to first response cycle; legal range 1..255.
REQ-002 SHALL have parameter MEM_LINES_LOG2, default 10: log2 of the backing store depth in 128-bit lines.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port list:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- snooper_addr  in  32  line address from the L1; bits [3:0] are ignored.
- snooper_read_valid  in  1  one-cycle miss read request.
- eviction_wren  in  1  write of evictable_cacheline to snooper_addr.
- evictable_cacheline  in  128  eviction write data.
- hotlink_interrupt  in  1  the L1 is under interrupt and ignores updates this cycle.
- updated_cacheline  out  128  response line data.
- cacheline_update_valid  out  1  response valid.
- busy  out  1  high whenever the state is not IDLE.
- protocol_error  out  1  sticky illegal-request flag.
- read_count  out  16  count of accepted reads.
- write_count  out  16  count of accepted writes.

Function
REQ-005 Backing store: 2^MEM_LINES_LOG2 x 128 bits, indexed by snooper_addr[4+MEM_LINES_LOG2-1:4]; upper address bits ignored, so aliasing is permitted.
REQ-006 Store contents: zero at simulation start; unaffected by reset.
REQ-007 FSM states: IDLE, WAIT, RESP.
REQ-008 IDLE & snooper_read_valid: latch the index, load the latency counter with LATENCY-1, go to WAIT; if LATENCY=1, go directly to RESP.
REQ-009 WAIT: decrement the counter each cycle; at counter==1 go to RESP, so the first RESP cycle is the acceptance edge + LATENCY.
REQ-010 RESP: cacheline_update_valid=1, updated_cacheline = store[latched index], read combinationally in that cycle.
REQ-011 RESP exit: go to IDLE at the first clock edge where hotlink_interrupt=0. While hotlink_interrupt=1, hold RESP with valid and data asserted.
REQ-012 Outside RESP: cacheline_update_valid=0 and updated_cacheline=0.
REQ-013 eviction_wren: accepted in every state, never stalled; store[index] <= evictable_cacheline at the clock edge.
REQ-014 Write during WAIT to the latched index: the response SHALL carry the written data (late read forwarding).
REQ-015 Write during RESP to the latched index: the current RESP cycle shows the pre-write data; the write is still committed.
REQ-016 Same-cycle snooper_read_valid and eviction_wren in IDLE: both accepted; the read returns the post-write contents when the indices match.
REQ-017 snooper_read_valid while not IDLE: the request is ignored (no state or counter change) and protocol_error is set to 1 until reset.
REQ-018 read_count: +1 per accepted read. write_count: +1 per eviction_wren cycle. Both wrap modulo 2^16; same-cycle increments are independent.
REQ-019 busy: a registered state decode, 1 in WAIT and RESP.

Reset
REQ-020 On reset assertion, immediately: state=IDLE, counter=0, cacheline_update_valid=0, updated_cacheline=0, busy=0, protocol_error=0, read_count=0, write_count=0.
REQ-021 Reset mid-WAIT or mid-RESP: the pending read is dropped with no response after reset release; store contents, including writes committed before reset, are retained.
REQ-022 The first request SHALL be accepted on the first rising edge after reset deassertion.

Verification
REQ-023 LATENCY=4. Write 128'hDEAD...0001 to 0x0000_1230 at cycle 0; read 0x0000_1230 at cycle 2 -> valid=1 at cycle 6 only, data=128'hDEAD...0001, read_count=1, write_count=1.
REQ-024 Read 0x40 at cycle 0; eviction to 0x40 with 128'h5 at cycle 1 -> cycle 4 response data=128'h5.
REQ-025 Read at cycle 0; hotlink_interrupt=1 in cycles 4-5 -> valid high in cycles 4, 5, 6; IDLE and busy=0 after the cycle-6 edge.
REQ-026 Second snooper_read_valid at cycle 2 while WAIT -> ignored; protocol_error=1; read_count=1; one response only, at cycle 4.
REQ-027 Reset asserted at cycle 2 of a pending read -> valid never asserts; counters=0; a re-read returns the previously written data.
REQ-028 LATENCY=1, with reads to 0x0 and 0x4000 under MEM_LINES_LOG2=10 (aliasing) -> each response one cycle after acceptance, both with identical data.
